// File: rtl/gcd_request_ctrl.sv
// Valid/ready front end for the next_GCD core: 2-entry operand FIFO, Go/Done
// sequencing and local zero-operand bypass. Optional WAIT watchdog: GCD_TIMEOUT_EN.
module gcd_request_ctrl #(
  parameter int unsigned WIDTH          = 5,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             InValid,
  output logic             InReady,
  input  logic [WIDTH-1:0] InX,
  input  logic [WIDTH-1:0] InY,
  output logic [WIDTH-1:0] GcdX,
  output logic [WIDTH-1:0] GcdY,
  output logic             GcdGo,
  input  logic             GcdDone,
  input  logic [WIDTH-1:0] GcdResult,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] OutX,
  output logic [WIDTH-1:0] OutY,
  output logic [WIDTH-1:0] OutGcd,
  output logic             OutErr
);

  localparam int unsigned DEPTH = 2;
  localparam int unsigned CNT_W = 2;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_HOLD} state_t;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_t           r_state;
  state_t           w_state_nxt;

  logic [WIDTH-1:0] r_fifo_x [DEPTH];
  logic [WIDTH-1:0] r_fifo_y [DEPTH];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_nxt;
  logic             r_in_ready;

  logic [WIDTH-1:0] r_gcd_x;
  logic [WIDTH-1:0] r_gcd_y;
  logic             r_go;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_x;
  logic [WIDTH-1:0] r_out_y;
  logic [WIDTH-1:0] r_out_gcd;

  logic             w_push;
  logic             w_pop;
  logic             w_head_zero;
  logic             w_timeout;
  logic [WIDTH-1:0] w_head_x;
  logic [WIDTH-1:0] w_head_y;

  assign w_push      = InValid & r_in_ready;
  assign w_pop       = (r_state == S_IDLE) && (r_count != '0);
  assign w_head_x    = r_fifo_x[r_rd_ptr];
  assign w_head_y    = r_fifo_y[r_rd_ptr];
  assign w_head_zero = (w_head_x == '0) || (w_head_y == '0);

  // FIFO occupancy; InReady is re-registered from the next count
  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + CNT_W'(1);
    end else if (!w_push && w_pop) begin
      w_count_nxt = r_count - CNT_W'(1);
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_count    <= '0;
      r_in_ready <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      r_count    <= w_count_nxt;
      r_in_ready <= (w_count_nxt < CNT_W'(DEPTH));
    end
  end

  always_ff @(posedge Clock) begin
    if (w_push) begin
      r_fifo_x[r_wr_ptr] <= InX;
      r_fifo_y[r_wr_ptr] <= InY;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_pop) w_state_nxt = w_head_zero ? S_HOLD : S_ISSUE;
      S_ISSUE: w_state_nxt = S_WAIT;
      S_WAIT:  if (GcdDone || w_timeout) w_state_nxt = S_HOLD;
      S_HOLD:  if (OutReady) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Go and OutValid are registered copies of the next-state decode
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_go        <= 1'b0;
      r_out_valid <= 1'b0;
      r_gcd_x     <= '0;
      r_gcd_y     <= '0;
      r_out_x     <= '0;
      r_out_y     <= '0;
      r_out_gcd   <= '0;
    end else begin
      r_go        <= (w_state_nxt == S_ISSUE);
      r_out_valid <= (w_state_nxt == S_HOLD);
      if (w_pop) begin
        r_out_x <= w_head_x;
        r_out_y <= w_head_y;
        if (w_head_zero) begin
          r_out_gcd <= w_head_x | w_head_y;
        end else begin
          r_gcd_x <= w_head_x;
          r_gcd_y <= w_head_y;
        end
      end
      if (r_state == S_WAIT) begin
        if (GcdDone) begin
          r_out_gcd <= GcdResult;
        end else if (w_timeout) begin
          r_out_gcd <= '0;
        end
      end
    end
  end

`ifdef GCD_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES) + 1;

  logic [TMO_W-1:0] r_tmo;
  logic             r_out_err;

  // r_tmo holds the number of WAIT cycles already spent
  assign w_timeout = (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_tmo     <= '0;
      r_out_err <= 1'b0;
    end else begin
      if (r_state == S_ISSUE) begin
        r_tmo <= '0;
      end else if (r_state == S_WAIT) begin
        r_tmo <= r_tmo + TMO_W'(1);
      end
      if (w_pop) begin
        r_out_err <= 1'b0;
      end else if (r_state == S_WAIT) begin
        if (GcdDone) begin
          r_out_err <= 1'b0;
        end else if (w_timeout) begin
          r_out_err <= 1'b1;
        end
      end
    end
  end

  assign OutErr = r_out_err;
`else
  assign w_timeout = 1'b0;
  assign OutErr    = 1'b0;
`endif

  assign InReady  = r_in_ready;
  assign GcdX     = r_gcd_x;
  assign GcdY     = r_gcd_y;
  assign GcdGo    = r_go;
  assign OutValid = r_out_valid;
  assign OutX     = r_out_x;
  assign OutY     = r_out_y;
  assign OutGcd   = r_out_gcd;

endmodule

// File: tb/tb_gcd_request_ctrl.sv
// Scoreboard bench for gcd_request_ctrl with a behavioural next_GCD core model.
`timescale 1ns/1ps
module tb_gcd_request_ctrl;
  localparam int unsigned W        = 5;
  localparam int          CORE_LAT = 4;

  typedef struct packed {
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] g;
    logic         err;
  } exp_t;

  logic         Clock = 1'b0;
  logic         Reset;
  logic         InValid;
  logic         InReady;
  logic [W-1:0] InX, InY;
  logic [W-1:0] GcdX, GcdY;
  logic         GcdGo;
  logic         GcdDone;
  logic [W-1:0] GcdResult;
  logic         OutValid;
  logic         OutReady;
  logic [W-1:0] OutX, OutY, OutGcd;
  logic         OutErr;

  int   n_checks = 0;
  int   n_errors = 0;
  int   go_cnt   = 0;
  exp_t sb_q[$];

  logic         core_hang;
  logic         core_done;
  logic [W-1:0] core_res;
  int           core_cnt;

  gcd_request_ctrl #(.WIDTH(W), .TIMEOUT_CYCLES(64)) dut (
    .Clock(Clock), .Reset(Reset),
    .InValid(InValid), .InReady(InReady), .InX(InX), .InY(InY),
    .GcdX(GcdX), .GcdY(GcdY), .GcdGo(GcdGo), .GcdDone(GcdDone), .GcdResult(GcdResult),
    .OutValid(OutValid), .OutReady(OutReady),
    .OutX(OutX), .OutY(OutY), .OutGcd(OutGcd), .OutErr(OutErr)
  );

  always #5 Clock = ~Clock;

  function automatic logic [W-1:0] euclid(input logic [W-1:0] a_in, input logic [W-1:0] b_in);
    logic [W-1:0] a, b, t;
    a = a_in;
    b = b_in;
    while (b != '0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // Core model: clears Done on Go, raises it CORE_LAT cycles after Go unless hung
  always @(posedge Clock) begin
    if (Reset) begin
      core_done <= 1'b0;
      core_cnt  <= 0;
      core_res  <= '0;
    end else if (GcdGo) begin
      core_done <= 1'b0;
      core_cnt  <= core_hang ? 0 : CORE_LAT - 1;
      core_res  <= euclid(GcdX, GcdY);
    end else if (core_cnt == 1) begin
      core_done <= 1'b1;
      core_cnt  <= 0;
    end else if (core_cnt > 1) begin
      core_cnt <= core_cnt - 1;
    end
  end
  assign GcdDone   = core_done;
  assign GcdResult = core_res;

  always @(posedge Clock) if (GcdGo) go_cnt <= go_cnt + 1;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  // Monitor: every accepted result is compared against the scoreboard head
  always @(negedge Clock) begin
    if (!Reset && OutValid && OutReady) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_result: got x=%0d y=%0d gcd=%0d, none expected", OutX, OutY, OutGcd);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("out_x",   64'(OutX),   64'(e.x));
        chk("out_y",   64'(OutY),   64'(e.y));
        chk("out_gcd", 64'(OutGcd), 64'(e.g));
        chk("out_err", 64'(OutErr), 64'(e.err));
      end
    end
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic push(input int x, input int y, input int g, input bit err, input bit track);
    exp_t e;
    InValid = 1'b1;
    InX = W'(x);
    InY = W'(y);
    for (int i = 0; i < 400; i++) begin
      if (InReady) begin
        if (track) begin
          e.x = W'(x); e.y = W'(y); e.g = W'(g); e.err = err;
          sb_q.push_back(e);
        end
        tick();
        InValid = 1'b0;
        return;
      end
      tick();
    end
    InValid = 1'b0;
    n_checks++;
    n_errors++;
    $display("FAIL push_timeout: got InReady=0 for 400 cycles, required acceptance of (%0d,%0d)", x, y);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 600 && sb_q.size() != 0; i++) tick();
    chk(name, 64'(sb_q.size()), 64'd0);
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g0;
    int n;
    Reset = 1'b1; InValid = 1'b0; InX = '0; InY = '0; OutReady = 1'b0; core_hang = 1'b0;
    tick(); tick();
    chk("rst_in_ready", 64'(InReady), 64'd1);
    chk("rst_outputs", 64'({GcdGo, OutValid, OutErr, GcdX, GcdY, OutX, OutY, OutGcd}), 64'd0);
    Reset = 1'b0;
    tick();

    // Basic GCD: Go in cycle 2, Done in cycle 6, OutValid in cycle 7
    OutReady = 1'b1;
    push(18, 10, 2, 1'b0, 1'b1);
    chk("basic_go_c1", 64'(GcdGo), 64'd0);
    tick();
    chk("basic_go_c2", 64'(GcdGo), 64'd1);
    chk("basic_gcd_x", 64'(GcdX), 64'd18);
    chk("basic_gcd_y", 64'(GcdY), 64'd10);
    tick();
    chk("basic_go_c3", 64'(GcdGo), 64'd0);
    tick(); tick(); tick();
    chk("basic_valid_c6", 64'(OutValid), 64'd0);
    tick();
    chk("basic_valid_c7", 64'(OutValid), 64'd1);
    drain("basic_drain");

    // Zero bypass: result in cycle 2, core never started
    g0 = go_cnt;
    push(0, 7, 7, 1'b0, 1'b1);
    chk("zero_valid_c1", 64'(OutValid), 64'd0);
    tick();
    chk("zero_valid_c2", 64'(OutValid), 64'd1);
    tick();
    push(0, 0, 0, 1'b0, 1'b1);
    drain("zero_drain");
    chk("zero_no_go", 64'(go_cnt - g0), 64'd0);

    // Push coincident with the IDLE pop leaves the count at 1
    push(21, 14, 7, 1'b0, 1'b1);
    push(16, 24, 8, 1'b0, 1'b1);
    chk("pushpop_count", 64'(dut.r_count), 64'd1);
    chk("pushpop_in_ready", 64'(InReady), 64'd1);
    drain("pushpop_drain");

    // Backpressure: 3 held, 4th stalls until the consumer drains
    OutReady = 1'b0;
    push(12, 8, 4, 1'b0, 1'b1);
    push(9, 6, 3, 1'b0, 1'b1);
    push(31, 1, 1, 1'b0, 1'b1);
    InValid = 1'b1; InX = W'(15); InY = W'(5);
    chk("bp_in_ready_full", 64'(InReady), 64'd0);
    fork
      begin
        repeat (12) tick();
        chk("bp_in_ready_held", 64'(InReady), 64'd0);
        OutReady = 1'b1;
      end
      push(15, 5, 5, 1'b0, 1'b1);
    join
    drain("bp_drain");

`ifdef GCD_TIMEOUT_EN
    // Timeout: 64 WAIT cycles (3..66) then HOLD in cycle 67
    core_hang = 1'b1;
    push(20, 4, 0, 1'b1, 1'b1);
    tick();
    chk("tmo_go_c2", 64'(GcdGo), 64'd1);
    n = 0;
    while (!OutValid && n < 200) begin
      tick();
      n++;
    end
    chk("tmo_latency", 64'(n), 64'd65);
    core_hang = 1'b0;
    tick();
    push(6, 4, 2, 1'b0, 1'b1);
    drain("tmo_drain");
`endif

    // Reset mid-WAIT with two entries queued
    core_hang = 1'b1;
    push(12, 8, 4, 1'b0, 1'b0);
    push(9, 6, 3, 1'b0, 1'b0);
    push(31, 1, 1, 1'b0, 1'b0);
    tick(); tick();
    chk("rmw_count_before", 64'(dut.r_count), 64'd2);
    Reset = 1'b1;
    tick();
    chk("rmw_in_ready", 64'(InReady), 64'd1);
    chk("rmw_outputs", 64'({GcdGo, OutValid, OutErr, GcdX, GcdY, OutX, OutY, OutGcd}), 64'd0);
    chk("rmw_count", 64'(dut.r_count), 64'd0);
    Reset = 1'b0;
    core_hang = 1'b0;
    tick();
    push(14, 21, 7, 1'b0, 1'b1);
    drain("rmw_drain");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
